inv_sub_bytes_iter: RTL
=======================

// Module: inv_sub_bytes_iter
// PURPOSE
//   AES decryption InvSubBytes stage: applies the FIPS-197 inverse S-box to all 16 state bytes.
//   Processes BYTES_PER_CYCLE bytes per clock through an internal inverse S-box table.
//   Sits directly downstream of the inverse row-shift stage and feeds the round-key add.
//   Valid/ready handshake on both sides; one block in flight at a time.
// PARAMETERS
//   BYTES_PER_CYCLE  4  bytes substituted per clock; legal values 1,2,4,8,16; any other value is an elaboration error
// PORTS
//   i_clock    in   1    clock; all state updates on the rising edge
//   i_reset_n  in   1    asynchronous active-low reset
//   i_data     in   128  [0:127] input state; byte i = bits [8i:8i+7]
//   i_valid    in   1    upstream offers i_data
//   o_ready    out  1    block can accept; high only in IDLE
//   o_data     out  128  [0:127] substituted state; byte i = InvSbox(input byte i)
//   o_valid    out  1    o_data holds a complete result
//   i_ready    in   1    downstream accepts o_data
//   o_busy     out  1    high in BUSY
// BEHAVIOUR
//   Reset (async, i_reset_n=0): state IDLE; o_ready=1, o_valid=0, o_busy=0; o_data=128'h0; chunk counter=0; source register=0.
//   State machine:
//     IDLE: o_ready=1. Accept on edge with i_valid=1 -> capture i_data into source reg, counter=0, go BUSY.
//           i_valid=0 -> remain IDLE. i_data need only be stable at the accept edge.
//     BUSY: o_ready=0, o_busy=1. Each edge: bytes [c*N .. c*N+N-1] (N=BYTES_PER_CYCLE, c=counter) are substituted
//           into the result reg; counter++. On the edge processing the last chunk (c=16/N-1) -> go DONE, o_valid=1.
//           i_valid ignored; i_ready ignored.
//     DONE: o_valid=1, o_ready=0. o_data held constant. Edge with i_ready=1 -> o_valid=0, go IDLE.
//           No same-cycle accept of a new block on the DONE->IDLE edge.
//   Byte order: chunks processed byte 0 first (bits [0:7]) through byte 15 (bits [120:127]).
//   Latency: accept edge to o_valid high = 16/N edges (N=4: 4; N=16: 1; N=1: 16).
//   Throughput: one block per 16/N + 2 cycles with i_valid and i_ready both held high.
//   o_data: result register drives it directly; bytes not yet written in BUSY retain the previous block's values;
//     only meaningful while o_valid=1. Not cleared on leaving DONE.
//   Counter width ceil(log2(16/N)), min 1 bit; wraps to 0 on the DONE transition.
//   Inverse S-box: full 256-entry FIPS-197 table, combinational, one instance per byte lane (N instances).
//   Reset mid-operation: block in progress discarded, outputs return to reset values immediately (asynchronous).
//   i_ready high outside DONE has no effect; i_valid high outside IDLE has no effect (no buffering).
// TESTING
//   1 Reset: hold i_reset_n=0 with i_valid=1 -> o_ready=1, o_valid=0, o_busy=0, o_data=0; release -> IDLE.
//   2 i_data=all 8'h63, i_valid pulse, i_ready=1 -> o_valid high 4 edges after accept, o_data=128'h0, back to IDLE.
//   3 i_data=all 8'h00 -> o_data=all 8'h52; i_data=16'h7c16 repeated (bytes 7c,16,...) -> bytes 01,ff repeated.
//   4 Backpressure: i_ready=0 for 10 cycles after o_valid -> o_data stable, o_ready=0, new i_valid ignored;
//     i_ready=1 -> o_valid drops next edge, o_ready=1.
//   5 Reset asserted during BUSY (2 edges after accept) -> immediate IDLE, o_valid never rises; next block correct.
//   6 Sweep: 16 blocks covering input bytes 0x00..0xff (byte i of block k = 16k+i) for N=1,4,16 -> each
//     byte equals FIPS-197 InvSbox; latency 16, 4, 1 edges; InvSbox(8'hed)=8'h53 checked explicitly.

Source files
------------

// File: rtl/inv_sub_bytes_iter.sv
// AES decryption InvSubBytes stage: substitutes the 16 state bytes BYTES_PER_CYCLE
// at a time through per-lane FIPS-197 inverse S-box lookups, valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for a block; o_ready high
// BUSY  | substituting one chunk of bytes per clock
// DONE  | result held on o_data until downstream takes it
module inv_sub_bytes_iter #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         i_clock,
    input  logic         i_reset_n,
    input  logic [0:127] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [0:127] o_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic         o_busy
);
    localparam int N          = BYTES_PER_CYCLE;
    localparam int NUM_CHUNKS = 16 / N;
    localparam int CW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(NUM_CHUNKS - 1);

    // Entry for input byte b sits at bits [8b:8b+7].
    localparam logic [0:2047] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    if (!(N == 1 || N == 2 || N == 4 || N == 8 || N == 16)) begin : g_bad_param
        $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   cnt_q;
    logic [0:127]    src_q;
    logic [0:127]    result_q;
    logic [6:0]      chunk_base;
    logic [0:8*N-1]  src_chunk;
    logic [0:8*N-1]  sub_chunk;

    assign chunk_base = 7'(int'(cnt_q) * 8 * N);
    assign src_chunk  = src_q[chunk_base +: 8*N];

    for (genvar j = 0; j < N; j++) begin : g_lane
        assign sub_chunk[8*j +: 8] = INV_SBOX[{src_chunk[8*j +: 8], 3'b000} +: 8];
    end

    always_comb begin
        state_d = state_q;
        o_ready = 1'b0;
        o_valid = 1'b0;
        o_busy  = 1'b0;
        case (state_q)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) state_d = BUSY;
            end
            BUSY: begin
                o_busy = 1'b1;
                if (cnt_q == LAST_CHUNK) state_d = DONE;
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // Result bytes not yet overwritten keep the previous block's values.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q    <= '0;
            src_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        src_q <= i_data;
                        cnt_q <= '0;
                    end
                end
                BUSY: begin
                    result_q[chunk_base +: 8*N] <= sub_chunk;
                    cnt_q <= (cnt_q == LAST_CHUNK) ? '0 : cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_data = result_q;

endmodule
